part_select_sequencer: RTL and testbench
========================================

# part_select_sequencer

Serializes a DATA_W-bit word into SLICE_W-bit beats using descending indexed part-selects (data[base -: SLICE_W]), starting at a caller-supplied MSB index and stepping down by SLICE_W per beat. It sits between a word-wide producer and a narrow consumer. It turns the single static `-:` slice into a flow-controlled, multi-beat scheduler with valid/ready handshakes on both sides. Bits addressed below index 0 are zero-filled.

## Interface
- DATA_W, 16, input word width; must be a power of two, ≥ SLICE_W (elaboration assertion)
- SLICE_W, 4, beat width; must divide DATA_W
- IDX_W, $clog2(DATA_W), index width (derived; do not override)
- CNT_W, $clog2(DATA_W/SLICE_W)+1, slice-count width (derived)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  word request valid
- s_ready  out  1  sequencer can accept a word
- s_data  in  DATA_W  word to slice
- s_msb  in  IDX_W  MSB index of first slice
- s_count  in  CNT_W  number of beats, legal 1..DATA_W/SLICE_W
- m_valid  out  1  beat valid
- m_ready  in  1  consumer accepts beat
- m_data  out  SLICE_W  current slice
- m_idx  out  IDX_W+1  signed base index of current slice
- m_last  out  1  final beat of word
- busy  out  1  word in progress
- err  out  1  one-cycle pulse: illegal s_count accepted

## Operation
- States: IDLE, RUN.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready: capture s_data, set base=s_msb, remaining=s_count.
  - If s_count=0 or s_count>DATA_W/SLICE_W: drop the word, pulse err next cycle, stay IDLE.
  - Otherwise go to RUN.
- RUN:
  - s_ready=0, m_valid=1, busy=1.
  - m_data = word[base -: SLICE_W]; each bit with index <0 is 0 (never X).
  - m_idx=base; m_last=(remaining==1).
- On m_valid&&m_ready:
  - base -= SLICE_W (signed, IDX_W+1 bits, may go negative).
  - remaining -= 1.
  - If m_last: go to IDLE.
- Hold rule: while m_valid&&!m_ready, m_data, m_idx and m_last are stable.
- Reset values: state IDLE, s_ready=1 (combinational from state), m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, err=0.
- Reset mid-word: immediately abandon the word, m_valid deasserts asynchronously, and no further beats are issued for it.

## Timing
- Word accepted at edge N: first beat m_valid=1 in cycle N+1.
- Beat k is presented no earlier than cycle N+k.
- Throughput: count+1 cycles per word at full m_ready. One bubble exists between words because s_ready is asserted only in IDLE.
- Last beat accepted at edge M: s_ready=1 in cycle M+1.
- m_data/m_idx/m_last are registered outputs. No combinational path from m_ready to m_valid or m_data.
- s_ready depends only on state. No combinational path from s_valid.
- err asserts for exactly one cycle after the illegal acceptance.

## Structure
- Package part_sel_pkg holds:
  - state enum (IDLE, RUN)
  - function slices_per_word(DATA_W, SLICE_W)
  - function clog2-derived width helpers
- Sub-module part_sel_slice: combinational; inputs word and signed base; output is the SLICE_W slice with zero-fill below bit 0. Instantiated once; it performs the only `-:` select in the design.
- Top holds the FSM, base/remaining counters, output registers and the parameter assertions.

## Test plan
- s_data=16'hABCD, s_msb=15, s_count=4, m_ready=1 → beats A,B,C,D; m_idx 15,11,7,3; m_last only on D; s_ready back in 6th cycle.
- s_data=16'hABCD, s_msb=15, s_count=1 → single beat 4'hA with m_last=1 (equals a[15-:4]).
- s_data=16'h00FF, s_msb=5, s_count=2 → beat 4'hF (m_idx 5), then 4'hC (m_idx 1: bits 1,0 then zero-fill).
- 16'h1234, msb=15, count=4; m_ready=0 for 3 cycles while beat 2 is shown → 4'h2 and m_idx=11 held stable, no beat lost or duplicated.
- s_count=0, then s_count=5 → each accepted, err pulses once, no m_valid, sequencer stays IDLE.
- rst asserted during beat 2 of 16'hABCD → m_valid=0 immediately; after release, next word 16'h5A5A msb=15 count=4 yields 5,A,5,A only.

Source files
------------

// File: rtl/part_sel_pkg.sv
// -----------------------------------------------------------------------------
// part_sel_pkg
// Shared types and width helpers for the part-select sequencer.
//   state_t          : sequencer FSM states (IDLE, RUN)
//   slices_per_word  : number of SLICE_W beats that make up one DATA_W word
//   idx_width        : width of an unsigned bit index into a DATA_W word
//   cnt_width        : width able to hold a beat count of 0..slices_per_word
// -----------------------------------------------------------------------------
package part_sel_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int slices_per_word(input int data_w, input int slice_w);
      return data_w / slice_w;
   endfunction

   function automatic int idx_width(input int data_w);
      return $clog2(data_w);
   endfunction

   function automatic int cnt_width(input int data_w, input int slice_w);
      return $clog2(data_w / slice_w) + 1;
   endfunction

endpackage

// File: rtl/part_sel_slice.sv
// -----------------------------------------------------------------------------
// part_sel_slice
// Combinational extraction of word[base -: SLICE_W] for a signed base that may
// point below bit 0. Bits addressed below index 0 read as zero, never X.
// Ports:
//   word  in  DATA_W     source word
//   base  in  IDX_W+1    signed MSB index of the slice
//   slice out SLICE_W    extracted, zero-filled slice
// -----------------------------------------------------------------------------
module part_sel_slice #(
   parameter int DATA_W  = 16,
   parameter int SLICE_W = 4,
   parameter int IDX_W   = 4
) (
   input  logic [DATA_W-1:0]     word,
   input  logic signed [IDX_W:0] base,
   output logic [SLICE_W-1:0]    slice
);

   // The word is padded with zeros below bit 0 so that any slice that straddles
   // bit 0 stays inside the vector; slices wholly below bit 0 are forced to
   // zero instead. Two slices of padding keep the lowest selected bit >= 0.
   localparam int PAD_W  = 2 * SLICE_W;
   localparam int EXT_W  = DATA_W + PAD_W;
   localparam int EXT_IW = $clog2(EXT_W);

   logic [EXT_W-1:0]  ext;
   logic [EXT_IW-1:0] ext_idx;
   int                base_int;

   assign ext = {word, {PAD_W{1'b0}}};

   // NOTE: every variable written in an always_comb gets a default first so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      base_int = int'(base);
      ext_idx  = EXT_IW'(base_int + PAD_W);
      slice    = '0;
      if (base_int > -SLICE_W) begin
         slice = ext[ext_idx -: SLICE_W];
      end
   end

endmodule

// File: rtl/part_select_sequencer.sv
// -----------------------------------------------------------------------------
// part_select_sequencer
// Serializes a DATA_W word into SLICE_W beats, starting at a caller-supplied
// MSB index and stepping down by SLICE_W per beat (bits below 0 read as zero).
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready   word request handshake (s_ready depends only on state)
//   s_data            word to slice
//   s_msb             MSB index of the first slice
//   s_count           number of beats, legal 1..DATA_W/SLICE_W
//   m_valid/m_ready   beat handshake
//   m_data            current slice (registered)
//   m_idx             signed base index of the current slice (registered)
//   m_last            final beat of the word (registered)
//   busy              word in progress
//   err               one-cycle pulse after an illegal s_count was accepted
// -----------------------------------------------------------------------------
module part_select_sequencer
   import part_sel_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int SLICE_W = 4,
   parameter int IDX_W   = idx_width(DATA_W),
   parameter int CNT_W   = cnt_width(DATA_W, SLICE_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_W-1:0]     s_data,
   input  logic [IDX_W-1:0]      s_msb,
   input  logic [CNT_W-1:0]      s_count,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [SLICE_W-1:0]    m_data,
   output logic signed [IDX_W:0] m_idx,
   output logic                  m_last,
   output logic                  busy,
   output logic                  err
);

   localparam int                    SPW       = slices_per_word(DATA_W, SLICE_W);
   localparam logic [CNT_W-1:0]      MAX_COUNT = CNT_W'(SPW);
   localparam logic signed [IDX_W:0] STEP      = (IDX_W + 1)'(SLICE_W);

   // Parameter legality, checked at elaboration.
   if ((DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
      $error("part_select_sequencer: DATA_W must be a power of two");
   end
   if (SLICE_W < 1 || DATA_W < SLICE_W || (DATA_W % SLICE_W) != 0) begin : g_bad_slice_w
      $error("part_select_sequencer: SLICE_W must divide DATA_W");
   end
   if (IDX_W != idx_width(DATA_W) || CNT_W != cnt_width(DATA_W, SLICE_W)) begin : g_bad_derived
      $error("part_select_sequencer: IDX_W and CNT_W are derived and must not be overridden");
   end

   state_t                state, state_next;
   logic [DATA_W-1:0]     word_q, word_sel;
   logic signed [IDX_W:0] base_q, base_next, base_sel;
   logic [CNT_W-1:0]      rem_q;
   logic [SLICE_W-1:0]    slice, data_q;
   logic                  last_q, err_q;
   logic                  accept, illegal, load, beat;

   assign accept    = s_valid && (state == IDLE);
   assign illegal   = (s_count == '0) || (s_count > MAX_COUNT);
   assign load      = accept && !illegal;
   assign beat      = (state == RUN) && m_ready;
   assign base_next = base_q - STEP;

   // The single slicer serves both the first beat (fresh input word at s_msb)
   // and every following beat (held word at the stepped-down base), so the
   // beat registers always load a precomputed slice.
   assign word_sel = load ? s_data : word_q;
   assign base_sel = load ? {1'b0, s_msb} : base_next;

   part_sel_slice #(
      .DATA_W  (DATA_W),
      .SLICE_W (SLICE_W),
      .IDX_W   (IDX_W)
   ) u_slice (
      .word  (word_sel),
      .base  (base_sel),
      .slice (slice)
   );

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every flop samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            if (load) begin
               state_next = RUN;
            end
         end
         RUN: begin
            m_valid = 1'b1;
            busy    = 1'b1;
            if (m_ready && last_q) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset too, because their values are
   // visible on m_data/m_idx/m_last and must read as zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         base_q <= '0;
         rem_q  <= '0;
         data_q <= '0;
         last_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         err_q <= accept && illegal;
         if (load) begin
            word_q <= s_data;
            base_q <= base_sel;
            rem_q  <= s_count;
            data_q <= slice;
            last_q <= (s_count == CNT_W'(1));
         end else if (beat) begin
            base_q <= base_next;
            rem_q  <= rem_q - CNT_W'(1);
            if (last_q) begin
               last_q <= 1'b0;
            end else begin
               data_q <= slice;
               // The beat being loaded is the final one when two remain now.
               last_q <= (rem_q == CNT_W'(2));
            end
         end
      end
   end

   assign m_data = data_q;
   assign m_idx  = base_q;
   assign m_last = last_q;
   assign err    = err_q;

endmodule

// File: tb/tb_part_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_part_select_sequencer
// Self-checking bench: directed scenarios plus randomized words compared with
// a behavioural beat model computed from shifts of the source word.
// -----------------------------------------------------------------------------
module tb_part_select_sequencer;

   localparam int DATA_W  = 16;
   localparam int SLICE_W = 4;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 3;
   localparam int SPW     = DATA_W / SLICE_W;
   localparam int BOUND   = 60;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  s_valid = 1'b0;
   logic                  s_ready;
   logic [DATA_W-1:0]     s_data = '0;
   logic [IDX_W-1:0]      s_msb = '0;
   logic [CNT_W-1:0]      s_count = '0;
   logic                  m_valid;
   logic                  m_ready = 1'b0;
   logic [SLICE_W-1:0]    m_data;
   logic signed [IDX_W:0] m_idx;
   logic                  m_last;
   logic                  busy;
   logic                  err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   int idle_cyc = 0;

   logic [SLICE_W-1:0] obs_data[$];
   int                 obs_idx[$];
   logic               obs_last[$];
   int                 obs_cyc[$];

   part_select_sequencer #(
      .DATA_W  (DATA_W),
      .SLICE_W (SLICE_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_msb   (s_msb),
      .s_count (s_count),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_idx   (m_idx),
      .m_last  (m_last),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Beats are recorded mid-cycle; one seen here is taken at the next edge.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         obs_data.push_back(m_data);
         obs_idx.push_back(int'(m_idx));
         obs_last.push_back(m_last);
         obs_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected beat: the SLICE_W bits ending at 'base', zero below bit 0.
   function automatic logic [SLICE_W-1:0] ref_beat(input logic [DATA_W-1:0] w, input int base);
      logic [DATA_W+SLICE_W-1:0] t;
      t = '0;
      if (base >= SLICE_W - 1) t = {{SLICE_W{1'b0}}, w} >> (base - SLICE_W + 1);
      else if (base > -SLICE_W) t = {{SLICE_W{1'b0}}, w} << (SLICE_W - 1 - base);
      return t[SLICE_W-1:0];
   endfunction

   task automatic clear_obs();
      obs_data.delete();
      obs_idx.delete();
      obs_last.delete();
      obs_cyc.delete();
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w, input int msb, input int count);
      bit done = 1'b0;
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = w;
      s_msb   = IDX_W'(msb);
      s_count = CNT_W'(count);
      for (int i = 0; i < BOUND && !done; i++) begin
         @(negedge clk);
         if (s_ready) begin
            acc_cyc = cyc;
            done    = 1'b1;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL send_word accept: s_ready stayed %0b, required 1 within %0d cycles", s_ready, BOUND);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < BOUND && !done; i++) begin
         @(negedge clk);
         if (s_ready) begin
            idle_cyc = cyc;
            done     = 1'b1;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s idle timeout: s_ready=%0b, required 1 within %0d cycles", name, s_ready, BOUND);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks += 7;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset s_ready: got %b, required 1", s_ready); end
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset m_valid: got %b, required 0", m_valid); end
      if (m_data !== '0) begin n_fail++; $display("FAIL reset m_data: got %h, required 0", m_data); end
      if (m_idx !== '0) begin n_fail++; $display("FAIL reset m_idx: got %0d, required 0", m_idx); end
      if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset m_last: got %b, required 0", m_last); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", busy); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b, required 0", err); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post-reset idle: s_ready=%b m_valid=%b, required 1/0", s_ready, m_valid);
      end
   endtask

   task automatic test_abcd();
      logic [SLICE_W-1:0] exp_d[4];
      exp_d = '{4'hA, 4'hB, 4'hC, 4'hD};
      clear_obs();
      m_ready = 1'b1;
      send_word(16'hABCD, 15, 4);
      wait_idle("abcd");
      n_checks++;
      if (obs_data.size() != 4) begin
         n_fail++;
         $display("FAIL abcd beat count: got %0d, required 4", obs_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks += 4;
            if (obs_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL abcd data[%0d]: got %h, required %h", k, obs_data[k], exp_d[k]); end
            if (obs_idx[k] != 15 - 4 * k) begin n_fail++; $display("FAIL abcd idx[%0d]: got %0d, required %0d", k, obs_idx[k], 15 - 4 * k); end
            if (obs_last[k] !== (k == 3)) begin n_fail++; $display("FAIL abcd last[%0d]: got %b, required %b", k, obs_last[k], k == 3); end
            if (obs_cyc[k] != acc_cyc + 1 + k) begin n_fail++; $display("FAIL abcd timing[%0d]: got cycle %0d, required %0d", k, obs_cyc[k], acc_cyc + 1 + k); end
         end
      end
      n_checks++;
      if (idle_cyc != acc_cyc + 5) begin
         n_fail++;
         $display("FAIL abcd s_ready return: got cycle %0d, required %0d", idle_cyc, acc_cyc + 5);
      end
   endtask

   task automatic test_single();
      clear_obs();
      m_ready = 1'b1;
      send_word(16'hABCD, 15, 1);
      wait_idle("single");
      n_checks++;
      if (obs_data.size() != 1) begin
         n_fail++;
         $display("FAIL single beat count: got %0d, required 1", obs_data.size());
      end else begin
         n_checks += 3;
         if (obs_data[0] !== 4'hA) begin n_fail++; $display("FAIL single data: got %h, required a", obs_data[0]); end
         if (obs_idx[0] != 15) begin n_fail++; $display("FAIL single idx: got %0d, required 15", obs_idx[0]); end
         if (obs_last[0] !== 1'b1) begin n_fail++; $display("FAIL single last: got %b, required 1", obs_last[0]); end
      end
   endtask

   task automatic test_zero_fill();
      clear_obs();
      m_ready = 1'b1;
      send_word(16'h00FF, 5, 2);
      wait_idle("zero_fill");
      n_checks++;
      if (obs_data.size() != 2) begin
         n_fail++;
         $display("FAIL zero_fill beat count: got %0d, required 2", obs_data.size());
      end else begin
         n_checks += 5;
         if (obs_data[0] !== 4'hF) begin n_fail++; $display("FAIL zero_fill data0: got %h, required f", obs_data[0]); end
         if (obs_idx[0] != 5) begin n_fail++; $display("FAIL zero_fill idx0: got %0d, required 5", obs_idx[0]); end
         if (obs_data[1] !== 4'hC) begin n_fail++; $display("FAIL zero_fill data1: got %h, required c", obs_data[1]); end
         if (obs_idx[1] != 1) begin n_fail++; $display("FAIL zero_fill idx1: got %0d, required 1", obs_idx[1]); end
         if (obs_last[1] !== 1'b1 || obs_last[0] !== 1'b0) begin n_fail++; $display("FAIL zero_fill last: got %b%b, required 01", obs_last[0], obs_last[1]); end
      end
   endtask

   task automatic test_backpressure();
      logic [SLICE_W-1:0] exp_d[4];
      exp_d = '{4'h1, 4'h2, 4'h3, 4'h4};
      clear_obs();
      m_ready = 1'b1;
      send_word(16'h1234, 15, 4);
      @(posedge clk); #1;
      m_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks += 3;
         if (m_valid !== 1'b1) begin n_fail++; $display("FAIL hold m_valid cycle %0d: got %b, required 1", c, m_valid); end
         if (m_data !== 4'h2) begin n_fail++; $display("FAIL hold m_data cycle %0d: got %h, required 2", c, m_data); end
         if (m_idx !== 5'sd11 || m_last !== 1'b0) begin n_fail++; $display("FAIL hold idx/last cycle %0d: got %0d/%b, required 11/0", c, m_idx, m_last); end
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_idle("backpressure");
      n_checks++;
      if (obs_data.size() != 4) begin
         n_fail++;
         $display("FAIL backpressure beat count: got %0d, required 4", obs_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks += 2;
            if (obs_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL backpressure data[%0d]: got %h, required %h", k, obs_data[k], exp_d[k]); end
            if (obs_idx[k] != 15 - 4 * k) begin n_fail++; $display("FAIL backpressure idx[%0d]: got %0d, required %0d", k, obs_idx[k], 15 - 4 * k); end
         end
      end
   endtask

   task automatic test_illegal();
      int counts[2];
      counts = '{0, 5};
      for (int t = 0; t < 2; t++) begin
         int  pulses = 0;
         bit  valid_seen = 1'b0;
         bit  left_idle = 1'b0;
         clear_obs();
         m_ready = 1'b1;
         send_word(16'hFFFF, 15, counts[t]);
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
               n_checks++;
               if (err !== 1'b1) begin n_fail++; $display("FAIL illegal count=%0d err timing: got %b, required 1", counts[t], err); end
            end
            if (err) pulses++;
            if (m_valid) valid_seen = 1'b1;
            if (!s_ready) left_idle = 1'b1;
         end
         n_checks += 3;
         if (pulses != 1) begin n_fail++; $display("FAIL illegal count=%0d err pulses: got %0d, required 1", counts[t], pulses); end
         if (valid_seen || obs_data.size() != 0) begin n_fail++; $display("FAIL illegal count=%0d beats: got %0d, required 0", counts[t], obs_data.size()); end
         if (left_idle) begin n_fail++; $display("FAIL illegal count=%0d state: left IDLE, required stay IDLE", counts[t]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] w1, w2;
      int a1, a2;
      w1 = DATA_W'($urandom);
      w2 = DATA_W'($urandom);
      clear_obs();
      m_ready = 1'b1;
      send_word(w1, 15, 2);
      a1 = acc_cyc;
      send_word(w2, 7, 3);
      a2 = acc_cyc;
      wait_idle("back_to_back");
      n_checks += 2;
      if (a2 != a1 + 3) begin n_fail++; $display("FAIL back_to_back spacing: got %0d cycles, required 3", a2 - a1); end
      if (idle_cyc != a2 + 4) begin n_fail++; $display("FAIL back_to_back idle: got cycle %0d, required %0d", idle_cyc, a2 + 4); end
      n_checks++;
      if (obs_data.size() != 5) begin
         n_fail++;
         $display("FAIL back_to_back beat count: got %0d, required 5", obs_data.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            int base;
            logic [SLICE_W-1:0] exp;
            base = (k < 2) ? 15 - 4 * k : 7 - 4 * (k - 2);
            exp  = (k < 2) ? ref_beat(w1, base) : ref_beat(w2, base);
            n_checks += 2;
            if (obs_data[k] !== exp) begin n_fail++; $display("FAIL back_to_back data[%0d]: got %h, required %h", k, obs_data[k], exp); end
            if (obs_idx[k] != base) begin n_fail++; $display("FAIL back_to_back idx[%0d]: got %0d, required %0d", k, obs_idx[k], base); end
         end
      end
   endtask

   task automatic test_reset_mid_word();
      clear_obs();
      m_ready = 1'b1;
      send_word(16'hABCD, 15, 4);
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 4'hB) begin
         n_fail++;
         $display("FAIL mid_reset pre: m_valid/m_data got %b/%h, required 1/b", m_valid, m_data);
      end
      #2 rst = 1'b1;
      #1;
      n_checks += 3;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset m_valid: got %b, required 0", m_valid); end
      if (busy !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset busy/s_ready: got %b/%b, required 0/1", busy, s_ready); end
      if (m_data !== '0 || m_idx !== '0 || m_last !== 1'b0) begin n_fail++; $display("FAIL mid_reset outputs: got %h/%0d/%b, required 0/0/0", m_data, m_idx, m_last); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs_data.size() != 1 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset abandoned beats: got %0d beats m_valid=%b, required 1 beat m_valid=0", obs_data.size(), m_valid);
      end
      clear_obs();
      send_word(16'h5A5A, 15, 4);
      wait_idle("mid_reset_next");
      n_checks++;
      if (obs_data.size() != 4) begin
         n_fail++;
         $display("FAIL mid_reset next count: got %0d, required 4", obs_data.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            logic [SLICE_W-1:0] exp;
            exp = (k % 2 == 0) ? 4'h5 : 4'hA;
            n_checks++;
            if (obs_data[k] !== exp) begin n_fail++; $display("FAIL mid_reset next data[%0d]: got %h, required %h", k, obs_data[k], exp); end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [DATA_W-1:0] w;
         int msb, count;
         bit done = 1'b0;
         w     = DATA_W'($urandom);
         msb   = $urandom_range(0, DATA_W - 1);
         count = $urandom_range(1, SPW);
         clear_obs();
         m_ready = ($urandom_range(0, 3) != 0);
         send_word(w, msb, count);
         m_ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < BOUND && !done; c++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            else begin
               @(posedge clk); #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
         end
         n_checks++;
         if (!done || obs_data.size() != count) begin
            n_fail++;
            $display("FAIL random[%0d] beat count: got %0d, required %0d", n, obs_data.size(), count);
         end else begin
            for (int k = 0; k < count; k++) begin
               int base;
               base = msb - k * SLICE_W;
               n_checks += 4;
               if (obs_data[k] !== ref_beat(w, base)) begin n_fail++; $display("FAIL random[%0d] data[%0d]: got %h, required %h (w=%h msb=%0d)", n, k, obs_data[k], ref_beat(w, base), w, msb); end
               if (obs_idx[k] != base) begin n_fail++; $display("FAIL random[%0d] idx[%0d]: got %0d, required %0d", n, k, obs_idx[k], base); end
               if (obs_last[k] !== (k == count - 1)) begin n_fail++; $display("FAIL random[%0d] last[%0d]: got %b, required %b", n, k, obs_last[k], k == count - 1); end
               if (obs_cyc[k] < acc_cyc + 1 + k) begin n_fail++; $display("FAIL random[%0d] early beat %0d: got cycle %0d, required >= %0d", n, k, obs_cyc[k], acc_cyc + 1 + k); end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_abcd();
      test_single();
      test_zero_fill();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      test_reset_mid_word();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
